// File: rtl/branch_target_buffer_pkg.sv
//------------------------------------------------------------------------------
// Module   : branch_target_buffer_pkg
// Brief    : Shared FSM encodings and entry field widths for the fetch BTB.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package branch_target_buffer_pkg;

  localparam logic [0:0] c_BTB_IDLE  = 1'b0;
  localparam logic [0:0] c_BTB_SWEEP = 1'b1;

  localparam int c_PC_W     = 32;
  localparam int c_TARGET_W = 30;

  function automatic int tagWidth(input int depth);
    return 30 - depth;
  endfunction

  function automatic int entryWidth(input int depth);
    return 1 + tagWidth(depth) + c_TARGET_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_entry_ram.sv
//------------------------------------------------------------------------------
// Module   : btb_entry_ram
// Brief    : Entry storage, one synchronous write port, one async read port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btb_entry_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 55
) (
  input  logic              clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  // No reset on purpose: the owning FSM clears entries by sweeping.
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
//------------------------------------------------------------------------------
// Module   : branch_target_buffer
// Brief    : Direct-mapped BTB with combinational lookup and sweep clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int BTB_DEPTH = 6,
  parameter int TAG_W     = 30 - BTB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic        btb_hitF,
  output logic [31:0] btb_targetF,
  input  logic        branchM,
  input  logic        actual_takeM,
  input  logic [31:0] pcM,
  input  logic [31:0] branch_targetM,
  input  logic        invalidate,
  output logic        btb_busy
);

  localparam int                   c_ENTRY_W   = 1 + TAG_W + c_TARGET_W;
  localparam logic [BTB_DEPTH-1:0] c_SIDX_LAST = '1;

  logic [0:0]           r_state;
  logic [BTB_DEPTH-1:0] r_sidx;

  logic                 w_sweep;
  logic                 w_update;
  logic                 w_wrEn;
  logic [BTB_DEPTH-1:0] w_wrIdx;
  logic [c_ENTRY_W-1:0] w_wrData;

  logic [BTB_DEPTH-1:0] w_rdIdx;
  logic [TAG_W-1:0]     w_rdTag;
  logic [c_ENTRY_W-1:0] w_rdEntry;
  logic                 w_rdValid;
  logic [TAG_W-1:0]     w_rdTagStored;
  logic [c_TARGET_W-1:0] w_rdTarget;

  logic                 w_unusedLowBits;

  // Invalidate during a sweep is deliberately ignored; the sweep never restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_BTB_SWEEP;
      r_sidx  <= '0;
    end else begin
      case (r_state)
        c_BTB_SWEEP: begin
          r_sidx <= r_sidx + 1'b1;
          if (r_sidx == c_SIDX_LAST) begin
            r_state <= c_BTB_IDLE;
          end
        end
        default: begin
          if (invalidate) begin
            r_state <= c_BTB_SWEEP;
            r_sidx  <= '0;
          end
        end
      endcase
    end
  end

  assign w_sweep  = (r_state == c_BTB_SWEEP);
  assign btb_busy = w_sweep;

  // Sweep clear owns the write port; an invalidate also kills a same-cycle update.
  assign w_update = !w_sweep && branchM && actual_takeM && !invalidate;
  assign w_wrEn   = w_sweep || w_update;
  assign w_wrIdx  = w_sweep ? r_sidx : pcM[BTB_DEPTH+1:2];
  assign w_wrData = w_sweep ? '0
                            : {1'b1, pcM[31:BTB_DEPTH+2], branch_targetM[31:2]};

  btb_entry_ram #(
    .ADDR_W (BTB_DEPTH),
    .DATA_W (c_ENTRY_W)
  ) u_ram (
    .clk      (clk),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (w_wrIdx),
    .i_wrData (w_wrData),
    .i_rdAddr (w_rdIdx),
    .o_rdData (w_rdEntry)
  );

  assign w_rdIdx       = pcF[BTB_DEPTH+1:2];
  assign w_rdTag       = pcF[31:BTB_DEPTH+2];
  assign w_rdValid     = w_rdEntry[c_ENTRY_W-1];
  assign w_rdTagStored = w_rdEntry[c_TARGET_W +: TAG_W];
  assign w_rdTarget    = w_rdEntry[c_TARGET_W-1:0];

  assign btb_hitF    = !w_sweep && w_rdValid && (w_rdTagStored == w_rdTag);
  assign btb_targetF = btb_hitF ? {w_rdTarget, 2'b00} : 32'h0;

  // Byte-offset bits carry no information for word-aligned fetch.
  assign w_unusedLowBits = ^{pcF[1:0], pcM[1:0], branch_targetM[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: scoreboarded lookups plus sweep-length checks.
`default_nettype none

module tb_branch_target_buffer;

  logic        clk            = 1'b0;
  logic        rst            = 1'b1;
  logic [31:0] pcF            = '0;
  logic        branchM        = 1'b0;
  logic        actual_takeM   = 1'b0;
  logic [31:0] pcM            = '0;
  logic [31:0] branch_targetM = '0;
  logic        invalidate     = 1'b0;
  logic        btb_hitF;
  logic [31:0] btb_targetF;
  logic        btb_busy;

  int nAsserts = 0;
  int nFail    = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] tgt;
    logic        busy;
  } exp_t;

  exp_t sbq[$];

  branch_target_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .pcF            (pcF),
    .btb_hitF       (btb_hitF),
    .btb_targetF    (btb_targetF),
    .branchM        (branchM),
    .actual_takeM   (actual_takeM),
    .pcM            (pcM),
    .branch_targetM (branch_targetM),
    .invalidate     (invalidate),
    .btb_busy       (btb_busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] f, input logic bM, input logic tM,
                       input logic [31:0] pM, input logic [31:0] tgt, input logic inv);
    @(posedge clk);
    #1;
    pcF            = f;
    branchM        = bM;
    actual_takeM   = tM;
    pcM            = pM;
    branch_targetM = tgt;
    invalidate     = inv;
  endtask

  task automatic expectOut(input string name, input logic hit, input logic [31:0] tgt,
                           input logic busy);
    exp_t e;
    e.name = name;
    e.hit  = hit;
    e.tgt  = tgt;
    e.busy = busy;
    sbq.push_back(e);
  endtask

  task automatic checkOut();
    exp_t e;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkVal({e.name, "/hit"},    {31'b0, btb_hitF}, {31'b0, e.hit});
      checkVal({e.name, "/target"}, btb_targetF,       e.tgt);
      checkVal({e.name, "/busy"},   {31'b0, btb_busy}, {31'b0, e.busy});
    end
  endtask

  task automatic step(input string name, input logic [31:0] f, input logic bM, input logic tM,
                      input logic [31:0] pM, input logic [31:0] tgt, input logic inv,
                      input logic eHit, input logic [31:0] eTgt, input logic eBusy);
    drive(f, bM, tM, pM, tgt, inv);
    expectOut(name, eHit, eTgt, eBusy);
    checkOut();
  endtask

  // Counts busy cycles from the next cycle on; keeps a taken update to an
  // already-swept index (0x4) asserted mid-sweep, which must be dropped.
  task automatic measureSweep(input string name, input logic [31:0] probe, input int pulseAt,
                              input bit doRelease);
    int n    = 0;
    int hits = 0;
    bit done = 1'b0;
    @(posedge clk);
    #1;
    if (doRelease) rst = 1'b1;
    pcF          = probe;
    branchM      = 1'b0;
    actual_takeM = 1'b0;
    invalidate   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!btb_busy || n > 200) begin
        done = 1'b1;
      end else begin
        n++;
        if (btb_hitF || btb_targetF != 32'h0) hits++;
        @(posedge clk);
        #1;
        invalidate     = (n == pulseAt);
        branchM        = (n >= 2 && n < 60);
        actual_takeM   = branchM;
        pcM            = 32'h0000_0004;
        branch_targetM = 32'h0000_8000;
      end
    end
    checkVal({name, "/busy_cycles"},     n,                 64);
    checkVal({name, "/hits_while_busy"}, hits,              0);
    checkVal({name, "/idle_after"},      {31'b0, btb_busy}, 32'h0);
  endtask

  initial begin
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("reset%0d", i), 32'h40, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    end
    measureSweep("post_reset", 32'h40, -1, 1'b1);

    // Allocate, then hit; same index with another tag misses.
    step("alloc",       32'h40,  1, 1, 32'h40,  32'h1000, 0, 0, 32'h0,    0);
    step("hit40",       32'h40,  0, 0, 32'h0,   32'h0,    0, 1, 32'h1000, 0);
    step("miss140",     32'h140, 0, 0, 32'h0,   32'h0,    0, 0, 32'h0,    0);

    step("not_taken",   32'h40,  1, 0, 32'h40,  32'h3000, 0, 1, 32'h1000, 0);
    step("nt_hold",     32'h40,  0, 0, 32'h0,   32'h0,    0, 1, 32'h1000, 0);

    step("alias_wr",    32'h140, 1, 1, 32'h140, 32'h2000, 0, 0, 32'h0,    0);
    step("alias_old",   32'h40,  0, 0, 32'h0,   32'h0,    0, 0, 32'h0,    0);
    step("alias_new",   32'h140, 0, 0, 32'h0,   32'h0,    0, 1, 32'h2000, 0);
    step("pc_low_bits", 32'h143, 0, 0, 32'h0,   32'h0,    0, 1, 32'h2000, 0);

    step("tgt_wr",      32'h0,   1, 1, 32'h200, 32'h9003, 0, 0, 32'h0,    0);
    step("tgt_low",     32'h200, 0, 0, 32'h0,   32'h0,    0, 1, 32'h9000, 0);

    // Same-cycle write and read of index 5: old contents that cycle.
    step("rw5_first",   32'h14,  1, 1, 32'h14,  32'h5000, 0, 0, 32'h0,    0);
    step("rw5_after",   32'h14,  0, 0, 32'h0,   32'h0,    0, 1, 32'h5000, 0);
    step("rw5_over",    32'h14,  1, 1, 32'h14,  32'h6000, 0, 1, 32'h5000, 0);
    step("rw5_new",     32'h14,  0, 0, 32'h0,   32'h0,    0, 1, 32'h6000, 0);

    // Invalidate colliding with an update, second pulse at sweep cycle 30.
    step("inv_collide", 32'h14,  1, 1, 32'h80,  32'h7000, 1, 1, 32'h6000, 0);
    measureSweep("inv_sweep", 32'h14, 30, 1'b0);
    step("inv_miss14",  32'h14,  0, 0, 32'h0,   32'h0,    0, 0, 32'h0,    0);
    step("inv_miss140", 32'h140, 0, 0, 32'h0,   32'h0,    0, 0, 32'h0,    0);
    step("inv_miss200", 32'h200, 0, 0, 32'h0,   32'h0,    0, 0, 32'h0,    0);
    step("lost_upd80",  32'h80,  0, 0, 32'h0,   32'h0,    0, 0, 32'h0,    0);
    step("drop_upd4",   32'h4,   0, 0, 32'h0,   32'h0,    0, 0, 32'h0,    0);

    // Reset asserted at sweep cycle 20 restarts a full sweep.
    step("pre_wr",      32'h14,  1, 1, 32'h14,  32'h6000, 0, 0, 32'h0,    0);
    step("inv2",        32'h14,  0, 0, 32'h0,   32'h0,    1, 1, 32'h6000, 0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sweep2_%0d", i), 32'h14, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    expectOut("rst_mid", 0, 32'h0, 1);
    checkOut();
    step("rst_hold",    32'h14,  0, 0, 32'h0,   32'h0,    0, 0, 32'h0,    1);
    measureSweep("rst_restart", 32'h14, -1, 1'b1);
    step("after_rst",   32'h14,  0, 0, 32'h0,   32'h0,    0, 0, 32'h0,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

`default_nettype wire
